// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus bundle.
// Groups the ALU write-back request, load-return handshake, decode-stage
// pending checks and the registered register-file write port.
//   slave  : arbiter side (consumes requests, drives ready/pending/write port)
//   master : producer side (drives requests and check addresses)
interface wb_arbiter_if #(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned REG_WIDTH      = 32
);
   logic                      alu_valid;
   logic [REG_ADDR_WIDTH-1:0] alu_addr;
   logic [REG_WIDTH-1:0]      alu_data;

   logic                      ld_valid;
   logic                      ld_ready;
   logic [REG_ADDR_WIDTH-1:0] ld_addr;
   logic [REG_WIDTH-1:0]      ld_data;

   logic [REG_ADDR_WIDTH-1:0] chk_rs1;
   logic [REG_ADDR_WIDTH-1:0] chk_rs2;
   logic                      pending_rs1;
   logic                      pending_rs2;

   logic                      wr_en;
   logic [REG_ADDR_WIDTH-1:0] addr_rd;
   logic [REG_WIDTH-1:0]      data_rd;

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  ld_valid, ld_addr, ld_data,
      output ld_ready,
      input  chk_rs1, chk_rs2,
      output pending_rs1, pending_rs2,
      output wr_en, addr_rd, data_rd
   );

   modport master (
      output alu_valid, alu_addr, alu_data,
      output ld_valid, ld_addr, ld_data,
      input  ld_ready,
      output chk_rs1, chk_rs2,
      input  pending_rs1, pending_rs2,
      input  wr_en, addr_rd, data_rd
   );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: owns the single register-file write port.
// ALU write-backs have fixed priority with no back-pressure; load returns
// arrive on a valid/ready handshake and are buffered in a small FIFO that
// drains whenever the ALU is idle. Queued loads are reported to decode via
// pending_rs1/pending_rs2 so it can stall on them.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset
//   bus   - wb_arbiter_if.slave (ALU request, load handshake, pending
//           checks, registered wr_en/addr_rd/data_rd)
module wb_arbiter #(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned REG_WIDTH      = 32,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input logic          clk,
   input logic          reset,
   wb_arbiter_if.slave  bus
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // FIFO storage; the valid bit lets an ALU write kill an older queued load
   logic                      ent_valid [FIFO_DEPTH];
   logic [REG_ADDR_WIDTH-1:0] ent_addr  [FIFO_DEPTH];
   logic [REG_WIDTH-1:0]      ent_data  [FIFO_DEPTH];

   logic [PTR_W-1:0]          rd_ptr;
   logic [PTR_W-1:0]          wr_ptr;
   logic [CNT_W-1:0]          count;

   logic                      wr_en_q;
   logic [REG_ADDR_WIDTH-1:0] addr_rd_q;
   logic [REG_WIDTH-1:0]      data_rd_q;

   logic ld_ready_c;
   logic push_c;
   logic pop_c;
   logic kill_c;
   logic pend1_c;
   logic pend2_c;
   logic [PTR_W-1:0] idx_c;

   // Handshake and arbitration decisions
   always_comb begin
      ld_ready_c = !reset && (count != CNT_W'(FIFO_DEPTH));
      // x0 loads complete the handshake but are dropped
      push_c     = bus.ld_valid && ld_ready_c && (bus.ld_addr != '0);
      pop_c      = !bus.alu_valid && (count != '0);
      kill_c     = bus.alu_valid && (bus.alu_addr != '0);
   end

   // Pending scan over occupied slots only, oldest first from the head
   always_comb begin
      pend1_c = 1'b0;
      pend2_c = 1'b0;
      idx_c   = '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
         idx_c = rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < count) && ent_valid[idx_c]) begin
            if (ent_addr[idx_c] == bus.chk_rs1) pend1_c = 1'b1;
            if (ent_addr[idx_c] == bus.chk_rs2) pend2_c = 1'b1;
         end
      end
      pend1_c = pend1_c && (bus.chk_rs1 != '0);
      pend2_c = pend2_c && (bus.chk_rs2 != '0);
   end

   // FIFO state and registered write port
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         wr_en_q   <= 1'b0;
         addr_rd_q <= '0;
         data_rd_q <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            ent_valid[i] <= 1'b0;
            ent_addr[i]  <= '0;
            ent_data[i]  <= '0;
         end
      end else begin
         // WAW kill of older entries; the same-cycle push below overrides it
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (kill_c && (ent_addr[i] == bus.alu_addr)) ent_valid[i] <= 1'b0;
         end

         if (push_c) begin
            ent_valid[wr_ptr] <= 1'b1;
            ent_addr[wr_ptr]  <= bus.ld_addr;
            ent_data[wr_ptr]  <= bus.ld_data;
            wr_ptr            <= wr_ptr + 1'b1;
         end

         if (bus.alu_valid) begin
            wr_en_q <= kill_c;
            if (kill_c) begin
               addr_rd_q <= bus.alu_addr;
               data_rd_q <= bus.alu_data;
            end
         end else if (pop_c) begin
            // A killed head still consumes the cycle, with no write
            wr_en_q <= ent_valid[rd_ptr];
            if (ent_valid[rd_ptr]) begin
               addr_rd_q <= ent_addr[rd_ptr];
               data_rd_q <= ent_data[rd_ptr];
            end
            rd_ptr <= rd_ptr + 1'b1;
         end else begin
            wr_en_q <= 1'b0;
         end

         if (push_c && !pop_c)      count <= count + 1'b1;
         else if (!push_c && pop_c) count <= count - 1'b1;
      end
   end

   assign bus.ld_ready    = ld_ready_c;
   assign bus.pending_rs1 = pend1_c;
   assign bus.pending_rs2 = pend2_c;
   assign bus.wr_en       = wr_en_q;
   assign bus.addr_rd     = addr_rd_q;
   assign bus.data_rd     = data_rd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed stimulus pushes the writes it expects
// into a queue; a negedge monitor pops and compares on every wr_en pulse.
module tb_wb_arbiter;
   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   wr_t  exp_q [$];

   wb_arbiter_if #(.REG_ADDR_WIDTH(5), .REG_WIDTH(32)) bus ();

   wb_arbiter #(
      .REG_ADDR_WIDTH(5),
      .REG_WIDTH     (32),
      .FIFO_DEPTH    (4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
      bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_data  = '0;
   endtask

   // Scoreboard monitor: every write pulse must match the oldest expectation
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, none expected",
                     bus.addr_rd, bus.data_rd);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (bus.addr_rd !== e.addr || bus.data_rd !== e.data) begin
               fails++;
               $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                        bus.addr_rd, bus.data_rd, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      tests = 0;
      fails = 0;
      idle_inputs();
      bus.chk_rs1 = '0;
      bus.chk_rs2 = '0;

      // Reset with a load offered the whole time
      reset = 1'b1;
      bus.ld_valid = 1'b1; bus.ld_addr = 5'd3; bus.ld_data = 32'h33;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_ld_ready", 32'(bus.ld_ready), 32'd0);
         chk("reset_wr_en", 32'(bus.wr_en), 32'd0);
         cyc();
      end
      reset = 1'b0;
      idle_inputs();
      bus.chk_rs1 = 5'd3;
      @(negedge clk);
      chk("post_reset_ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("post_reset_no_enqueue", 32'(bus.pending_rs1), 32'd0);
      chk("post_reset_addr_rd", 32'(bus.addr_rd), 32'd0);
      cyc();

      // ALU path: real write, then an x0 write that must not pulse wr_en
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEADBEEF;
      expect_wr(5'd5, 32'hDEADBEEF);
      cyc();
      bus.alu_addr = 5'd0; bus.alu_data = 32'h1234;
      cyc();
      idle_inputs();
      @(negedge clk);
      chk("alu_x0_wr_en", 32'(bus.wr_en), 32'd0);
      chk("alu_x0_hold_data", bus.data_rd, 32'hDEADBEEF);
      cyc();

      // Fill the FIFO while the ALU holds the port
      for (int j = 0; j < 4; j++) begin
         bus.alu_valid = 1'b1; bus.alu_addr = 5'd0;
         bus.ld_valid  = 1'b1; bus.ld_addr  = 5'(j + 1); bus.ld_data = 32'((j + 1) * 16);
         @(negedge clk);
         chk("fill_ld_ready", 32'(bus.ld_ready), 32'd1);
         cyc();
      end
      bus.ld_valid = 1'b0;
      bus.chk_rs1 = 5'd3;
      bus.chk_rs2 = 5'd5;
      @(negedge clk);
      chk("full_ld_ready", 32'(bus.ld_ready), 32'd0);
      chk("full_pending_rs1", 32'(bus.pending_rs1), 32'd1);
      chk("full_pending_rs2", 32'(bus.pending_rs2), 32'd0);
      cyc();

      // Drain: writes 1..4 back to back
      bus.alu_valid = 1'b0;
      for (int j = 1; j <= 4; j++) expect_wr(5'(j), 32'(j * 16));
      cyc();
      @(negedge clk);
      chk("drain1_pending", 32'(bus.pending_rs1), 32'd1);
      cyc();
      @(negedge clk);
      chk("drain2_pending", 32'(bus.pending_rs1), 32'd1);
      cyc();
      @(negedge clk);
      chk("drain3_presented_not_pending", 32'(bus.pending_rs1), 32'd0);
      cyc();
      @(negedge clk);
      chk("drained_ld_ready", 32'(bus.ld_ready), 32'd1);
      cyc();

      // WAW kill: ALU write to 7 invalidates the older queued load to 7
      bus.ld_valid = 1'b1; bus.ld_addr = 5'd7; bus.ld_data = 32'h77;
      bus.chk_rs1 = 5'd7;
      cyc();
      bus.ld_valid  = 1'b0;
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd7; bus.alu_data = 32'h99;
      expect_wr(5'd7, 32'h99);
      @(negedge clk);
      chk("waw_pending_before", 32'(bus.pending_rs1), 32'd1);
      cyc();
      bus.alu_valid = 1'b0;
      @(negedge clk);
      chk("waw_pending_after", 32'(bus.pending_rs1), 32'd0);
      cyc();
      @(negedge clk);
      chk("waw_killed_pop_wr_en", 32'(bus.wr_en), 32'd0);
      chk("waw_killed_hold_data", bus.data_rd, 32'h99);
      cyc();

      // Same-cycle load push and ALU write to the same register
      bus.ld_valid  = 1'b1; bus.ld_addr  = 5'd9; bus.ld_data  = 32'h1;
      bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 32'h2;
      bus.chk_rs1 = 5'd9;
      expect_wr(5'd9, 32'h2);
      expect_wr(5'd9, 32'h1);
      cyc();
      idle_inputs();
      @(negedge clk);
      chk("same_cycle_load_pending", 32'(bus.pending_rs1), 32'd1);
      cyc();
      cyc();

      // Reset mid-drain discards three queued loads
      for (int j = 0; j < 3; j++) begin
         bus.alu_valid = 1'b1; bus.alu_addr = 5'd0;
         bus.ld_valid  = 1'b1; bus.ld_addr  = 5'(10 + j); bus.ld_data = 32'(j + 100);
         cyc();
      end
      idle_inputs();
      bus.chk_rs1 = 5'd10;
      bus.chk_rs2 = 5'd12;
      @(negedge clk);
      chk("queued_pending_rs2", 32'(bus.pending_rs2), 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("post_mid_reset_wr_en", 32'(bus.wr_en), 32'd0);
         chk("post_mid_reset_pending_rs1", 32'(bus.pending_rs1), 32'd0);
         chk("post_mid_reset_pending_rs2", 32'(bus.pending_rs2), 32'd0);
         chk("post_mid_reset_ld_ready", 32'(bus.ld_ready), 32'd1);
         cyc();
      end

      @(negedge clk);
      chk("all_expected_writes_seen", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that owns the single write port of the register file. It merges two write-back sources into one registered (wr_en, addr_rd, data_rd) stream:
- a single-cycle ALU path with fixed priority and no back-pressure;
- a load-return path with a valid/ready handshake, buffered in a small FIFO.

It also reports which registers have load write-backs still queued, so decode can stall on them.

## Interface
- REG_ADDR_WIDTH, 5, register address width
- REG_WIDTH, 32, register data width
- FIFO_DEPTH, 4, load-return FIFO entries (power of two, >= 2)

- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- alu_valid  input  1  ALU write-back request this cycle
- alu_addr  input  REG_ADDR_WIDTH  ALU destination register
- alu_data  input  REG_WIDTH  ALU result
- ld_valid  input  1  load return valid
- ld_ready  output  1  FIFO can accept a load return
- ld_addr  input  REG_ADDR_WIDTH  load destination register
- ld_data  input  REG_WIDTH  load data
- chk_rs1, chk_rs2  input  REG_ADDR_WIDTH  decode-stage source addresses to check
- pending_rs1, pending_rs2  output  1  the corresponding chk address has a valid queued load
- wr_en  output  1  register-file write enable (registered)
- addr_rd  output  REG_ADDR_WIDTH  register-file write address (registered)
- data_rd  output  REG_WIDTH  register-file write data (registered)

## Operation
- Load handshake:
  - ld_ready = !reset && (count != FIFO_DEPTH), combinational; no full-bypass.
  - A transfer occurs when ld_valid && ld_ready.
  - A transfer with ld_addr == 0 is accepted and discarded (not enqueued).
  - Otherwise {valid=1, addr, data} is pushed at the tail.
- Each FIFO entry holds a valid bit, addr and data. Read/write pointers wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH.
- Arbitration, evaluated each cycle:
  - If alu_valid: the ALU wins and the FIFO is not popped. If alu_addr != 0, the outputs next cycle are wr_en=1, addr_rd=alu_addr, data_rd=alu_data. If alu_addr == 0, wr_en=0.
  - Else if count != 0: pop the head. If the head's valid bit is 1, issue its write. If it is 0, pop with wr_en=0; the cycle is still consumed.
  - Else: wr_en=0. addr_rd and data_rd hold their previous values.
- WAW protection: when alu_valid and alu_addr != 0, clear the valid bit of every FIFO entry already present whose addr == alu_addr.
  - A load pushed in the same cycle is younger than the ALU write and is not invalidated.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- pending_rsN (combinational) = chk_rsN != 0 && any FIFO entry (slots 0..count-1 from head) with valid=1 and addr == chk_rsN.
  - The entry currently being presented on the registered output does not count as pending.

## Timing
- Reset (synchronous, cycle reset is sampled high):
  - count = 0, pointers = 0, all valid bits = 0.
  - wr_en = 0, addr_rd = 0, data_rd = 0.
  - ld_ready = 0 while reset is high; 1 in the first cycle after reset deasserts.
  - A reset mid-operation discards all queued loads; no write is issued for them.
- ALU latency: alu_valid sampled at edge k gives wr_en high from edge k to edge k+1. The register file commits at edge k+1.
- Load latency with no ALU traffic:
  - Accepted at edge k, popped at edge k+1, wr_en high from k+1 to k+2.
  - Minimum 2 cycles.
- Sustained: one write per cycle; loads starve while alu_valid is high every cycle (by design).
- pending_rsN and ld_ready reflect state after the most recent edge and have no added latency.

## Test plan
- Reset: drive ld_valid=1 with reset high for 3 cycles, then release. Required: ld_ready=0 and wr_en=0 throughout reset; no enqueue; ld_ready=1 in the first cycle after release.
- ALU path: alu_valid with addr=5, data=0xDEADBEEF, then alu_valid with addr=0. Required: wr_en=1, addr_rd=5, data_rd=0xDEADBEEF one cycle later; wr_en=0 for the x0 write.
- Load path, fill then drain:
  - Push 4 loads (addr 1..4, data 0x10..0x40) while alu_valid=1 continuously. Required: ld_ready=0 after the 4th push; pending_rs1 high for chk_rs1=3; no load write occurs.
  - Drop alu_valid. Required: writes 1,2,3,4 on consecutive cycles, then ld_ready=1 and count=0.
- WAW kill: queue a load to addr 7 (data 0x77), then alu_valid to addr 7 (data 0x99). Required: the register file receives only 0x99; the popped load entry produces wr_en=0; pending_rs1 for 7 drops the cycle after the ALU write.
- Same-cycle push with ALU write: load to addr 9 (0x1) and ALU to addr 9 (0x2) in the same cycle. Required: write 0x2 first, then 0x1 the following cycle.
- Reset mid-drain: 3 loads queued, reset asserted for 1 cycle. Required: no further wr_en pulses; count=0; pending outputs low.
